// File: rtl/contador_desc_param.sv
// Parametrised down-counter/timer with runtime load, enable, and auto-reload or stop-at-zero mode.
// Latency: count/tc update one clk after the inputs; done follows the HALT state register directly.
// Optional macro CONTADOR_WRAPS_EN adds an 8-bit saturating reload counter on port wraps.
module contador_desc_param #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned INIT        = 2,
  parameter bit          AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
`ifdef CONTADOR_WRAPS_EN
  ,
  output logic [7:0]       wraps
`endif
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // State register: counter, reload value, terminal pulse and RUN/HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      count_q  <= INIT_V;
      reload_q <= INIT_V;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next state: load beats enable beats hold; decrement only from count >= 1 so it never underflows.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = RUN;
    end else if (state_q == RUN && en) begin
      if (count_q > ONE_V) begin
        count_d = count_q - ONE_V;
      end else if (count_q == ONE_V) begin
        count_d = '0;
        tc_d    = 1'b1;
      end else if (AUTO_RELOAD) begin
        // Zero reached while enabled: reload (a zero reload keeps it parked at 0 without tc).
        count_d = reload_q;
      end else begin
        state_d = HALT;
      end
    end
  end

  // Outputs: everything comes straight from registers.
  always_comb begin
    count = count_q;
    tc    = tc_q;
    done  = (state_q == HALT);
  end

`ifdef CONTADOR_WRAPS_EN
  logic       reload_evt;
  logic [7:0] wraps_q, wraps_d;

  assign reload_evt = AUTO_RELOAD && !load && (state_q == RUN) && en && (count_q == '0);

  // Reload counter: cleared by load, saturates at 255.
  always_comb begin
    wraps_d = wraps_q;
    if (load) begin
      wraps_d = 8'd0;
    end else if (reload_evt && wraps_q != 8'hFF) begin
      wraps_d = wraps_q + 8'd1;
    end
  end

  // Reload counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wraps_q <= 8'd0;
    end else begin
      wraps_q <= wraps_d;
    end
  end

  assign wraps = wraps_q;
`endif

endmodule

// File: doc/contador_desc_param.md
Name: contador_desc_param

Overview:
Parametrised down-counter/timer that generalises the team's fixed 2→1→0 counter to any width and start value. It supports runtime load, count enable, auto-reload or stop-at-zero mode, a terminal-count pulse and a done flag. It sits in the control datapath as a reusable countdown/timeout source for FSMs and display sequencing.

Parameters:
WIDTH, 4, counter width in bits (≥2).
INIT, 2, value of count and of the reload register after reset (must fit in WIDTH).
AUTO_RELOAD, 1, 1 = on reaching 0 and still enabled, reload and continue; 0 = stop at 0 (HALT).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
en  input  1  count enable; decrement one step per clk while high.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value captured by load into count and reload register.
count  output  WIDTH  current counter value (registered).
tc  output  1  terminal-count pulse, registered, one cycle wide.
done  output  1  high while halted at 0 (AUTO_RELOAD=0 only).
wraps  output  8  reload counter (present only with CONTADOR_WRAPS_EN).

Behaviour:
- Reset (reset=0, async): count=INIT, reload_reg=INIT, tc=0, done=0, state=RUN, wraps=0. Release is synchronous to clk by system design; first active edge after release acts normally.
- States: RUN, HALT. HALT reachable only when AUTO_RELOAD=0.
- Priority per edge: load > en > hold.
- load=1 (any state): count<=load_val, reload_reg<=load_val, state<=RUN, done<=0, tc<=0. load_val=0 gives count=0 with no tc; next enabled edge then treats 0 as terminal (reload or HALT, below).
- RUN, en=1, count>1: count<=count-1, tc<=0.
- RUN, en=1, count==1: count<=0, tc<=1 (tc high in the same cycle count first reads 0).
- RUN, en=1, count==0: AUTO_RELOAD=1 → count<=reload_reg, tc<=0, wraps increments; AUTO_RELOAD=0 → count stays 0, state<=HALT, done<=1.
- RUN, en=0: count holds, tc<=0.
- HALT: count held at 0, done=1, en ignored; exit only by load or reset.
- reload_reg=0 with AUTO_RELOAD=1: counter sits at 0 while enabled, tc never asserts, wraps increments every enabled edge.
- tc never asserted two consecutive cycles; period with AUTO_RELOAD=1, en held high, reload R≥1 = R+1 cycles.
- No arithmetic underflow: decrement only occurs when count≥1; count never wraps to all-ones.
- Reset mid-count: immediate return to reset values, regardless of en/load.

Optional Feature:
Macro CONTADOR_WRAPS_EN. Defined: port wraps[7:0] exists; increments on every auto-reload event; saturates at 255; cleared by reset and by load. Not defined: port and its register absent; all other behaviour identical.

Test Plan:
- Reset then en=1, WIDTH=4, INIT=2, AUTO_RELOAD=1: count 2,1,0,2,1,0…; tc=1 exactly when count=0; period 3 cycles.
- AUTO_RELOAD=0, load_val=5 then en=1: count 5,4,3,2,1,0 then held 0; tc one pulse at first 0; done=1 from next edge; further en has no effect.
- Load during count (count=3, en=1, load=1, load_val=9): next count=9 (load wins), tc=0; then continues 8,7…, reload value now 9.
- en toggled 0 at count=4 for 3 cycles: count stays 4, tc=0; resumes 3 on re-enable.
- Assert reset=0 asynchronously mid-cycle at count=7: count=2, tc=0, done=0 without waiting for clk; load_val=0 then en → count 0, no tc, wraps increments (with CONTADOR_WRAPS_EN).
- CONTADOR_WRAPS_EN, INIT=1, en held 600 cycles: wraps reaches 255 and holds; load clears it to 0.
